pe_row_feeder: RTL and testbench

- Drives one edge operand stream (in_vld/in_data) into the first PE of a systolic row or column. The stream is read from an operand RAM.
- Fetches len consecutive 8-bit operands starting at base_addr, with address wrap modulo DEPTH.
- Applies a programmable SKEW delay so that rows or columns enter the array staggered.
- Holds pe_en high for the whole job, then reports completion once the PE multiplier has drained.

---
 rtl/pe_row_feeder.sv | 149 ++++++++++++++
 tb/tb_pe_row_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_feeder.sv
// Operand feeder: streams len operands from the operand RAM (base_addr upward, wrapping) into the first PE of a systolic row/column.
// Latency: operand k leaves 2+k+SKEW cycles after job accept; done pulses 2 cycles after the pipeline and the PE have drained.
// Backpressure: stall only gates new RAM reads; every read already issued still reaches out_vld/out_data in order.
module pe_row_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8,
    parameter int SKEW  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          stall,
    input  logic          pe_doing,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data,
    output logic          pe_en,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE = 1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic          rd_pending_q;
    logic          done_q, done_d;
    logic [SKEW:0] vld_q;
    logic [DW-1:0] dat_q [0:SKEW];

    logic [AW:0]   len_clamp;
    logic          rd_fire;
    logic          last_rd;
    logic          drained;

    // Oversized lengths saturate at one full pass over the RAM.
    assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;

    // Reads are combinational on state so that reset silences the RAM port immediately.
    assign rd_fire     = (state_q == S_READ) && !stall;
    assign last_rd     = rd_fire && (rd_cnt_q == (len_q - CNT_ONE));
    assign ram_rd_en   = rd_fire;
    assign ram_rd_addr = base_q + rd_cnt_q[AW-1:0];

    // Nothing left in flight: no RAM response due, no operand in the skew pipe, PE idle.
    assign drained = !rd_pending_q && (vld_q == '0) && !pe_doing;

    assign out_vld  = vld_q[SKEW];
    assign out_data = dat_q[SKEW];
    assign pe_en    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    // Job FSM next-state: accept, issue reads, wait for drain, then a one-cycle done.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = len_clamp;
                    rd_cnt_d = '0;
                    state_d  = (len_clamp == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_fire) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end
                if (last_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Stay in DONE while done is high so a start alongside done is ignored.
                done_d = !done_q;
                if (done_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and job context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            rd_pending_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_pending_q <= ram_rd_en;
            done_q       <= done_d;
        end
    end

    // Capture RAM data into stage 0, then shift through SKEW stagger stages; data only moves with vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i <= SKEW; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_pending_q;
            if (rd_pending_q) begin
                dat_q[0] <= ram_rd_data;
            end
            for (int i = 1; i <= SKEW; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder: two instances (SKEW=0 and SKEW=3) share stimulus, each with its own RAM read port.
// Cycle c of a job is sampled just after edge T+c, where T is the accept edge.
module tb_pe_row_feeder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst, start, stall, pe_doing;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;

    logic          rd_en0, rd_en3, vld0, vld3, pe_en0, pe_en3, busy0, busy3, done0, done3;
    logic [AW-1:0] addr0, addr3;
    logic [DW-1:0] rdata0, rdata3, dat0, dat3;

    logic [DW-1:0] ram [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    logic [31:0] stall_m, pd_m, start_m;
    logic          tr_en0 [32];
    logic [AW-1:0] tr_addr0 [32];
    logic          tr_vld0 [32];
    logic [DW-1:0] tr_dat0 [32];
    logic          tr_done0 [32];
    logic          tr_pe0 [32];
    logic          tr_busy0 [32];
    logic          tr_vld3 [32];
    logic [DW-1:0] tr_dat3 [32];
    logic          tr_done3 [32];

    pe_row_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SKEW(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .stall(stall), .pe_doing(pe_doing), .ram_rd_en(rd_en0), .ram_rd_addr(addr0),
        .ram_rd_data(rdata0), .out_vld(vld0), .out_data(dat0), .pe_en(pe_en0),
        .busy(busy0), .done(done0)
    );

    pe_row_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SKEW(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .stall(stall), .pe_doing(pe_doing), .ram_rd_en(rd_en3), .ram_rd_addr(addr3),
        .ram_rd_data(rdata3), .out_vld(vld3), .out_data(dat3), .pe_en(pe_en3),
        .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    // Operand RAM model: one-cycle read latency per port.
    always @(posedge clk) begin
        if (rd_en0) rdata0 <= ram[addr0];
        if (rd_en3) rdata3 <= ram[addr3];
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Apply per-cycle masks and record both instances for n cycles.
    task automatic record(input int n);
        for (int c = 0; c < n; c++) begin
            stall    = stall_m[c];
            pe_doing = pd_m[c];
            start    = start_m[c];
            #1;
            tr_en0[c]   = rd_en0;
            tr_addr0[c] = addr0;
            tr_vld0[c]  = vld0;
            tr_dat0[c]  = dat0;
            tr_done0[c] = done0;
            tr_pe0[c]   = pe_en0;
            tr_busy0[c] = busy0;
            tr_vld3[c]  = vld3;
            tr_dat3[c]  = dat3;
            tr_done3[c] = done3;
            @(posedge clk);
            #1;
        end
        stall = 1'b0; pe_doing = 1'b0; start = 1'b0;
        stall_m = '0; pd_m = '0; start_m = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; pe_doing = 1'b0; base_addr = '0; len = '0;
        stall_m = '0; pd_m = '0; start_m = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_en0 !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0h expected 0", rd_en0); end
        checks++; if (addr0 !== 3'd0) begin errors++; $display("FAIL reset_rd_addr: got %0h expected 0", addr0); end
        checks++; if (vld0 !== 1'b0 || vld3 !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %0h/%0h expected 0/0", vld0, vld3); end
        checks++; if (dat0 !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", dat0); end
        checks++; if (pe_en0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got pe_en=%0h busy=%0h done=%0h expected 0", pe_en0, busy0, done0); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n;
        start_m = 32'h1 << 8;                   // start during the done cycle must be ignored
        do_start(3'd0, 4'd4);
        base_addr = 3'd5; len = 4'd4;
        record(20);
        for (int k = 0; k < 4; k++) begin
            checks++; if (tr_en0[k] !== 1'b1 || tr_addr0[k] !== 3'(k)) begin errors++; $display("FAIL basic_addr%0d: got en=%0h addr=%0d expected en=1 addr=%0d", k, tr_en0[k], tr_addr0[k], k); end
            checks++; if (tr_vld0[2+k] !== 1'b1 || tr_dat0[2+k] !== 8'(17*(k+1))) begin errors++; $display("FAIL basic_out%0d: got vld=%0h data=%0h expected vld=1 data=%0h", k, tr_vld0[2+k], tr_dat0[2+k], 8'(17*(k+1))); end
        end
        checks++; if (tr_en0[4] !== 1'b0) begin errors++; $display("FAIL basic_extra_read: got %0h expected 0", tr_en0[4]); end
        checks++; if (tr_vld0[1] !== 1'b0 || tr_vld0[6] !== 1'b0) begin errors++; $display("FAIL basic_vld_edges: got %0h/%0h expected 0/0", tr_vld0[1], tr_vld0[6]); end
        checks++; if (tr_pe0[6] !== 1'b1 || tr_pe0[7] !== 1'b0) begin errors++; $display("FAIL basic_pe_en: got %0h/%0h expected 1/0", tr_pe0[6], tr_pe0[7]); end
        n = 0;
        for (int c = 0; c < 20; c++) n += int'(tr_done0[c]);
        checks++; if (n !== 1 || tr_done0[8] !== 1'b1) begin errors++; $display("FAIL basic_done: got count=%0d at8=%0h expected 1/1", n, tr_done0[8]); end
        checks++; if (tr_busy0[9] !== 1'b0) begin errors++; $display("FAIL basic_start_in_done: got busy=%0h expected 0", tr_busy0[9]); end
    endtask

    task automatic test_skew3();
        int f0, f3;
        do_start(3'd0, 4'd4);
        record(20);
        f0 = -1; f3 = -1;
        for (int c = 19; c >= 0; c--) begin
            if (tr_vld0[c]) f0 = c;
            if (tr_vld3[c]) f3 = c;
        end
        checks++; if (f3 - f0 !== 3 || f0 !== 2) begin errors++; $display("FAIL skew3_delay: got first0=%0d first3=%0d expected 2/5", f0, f3); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (tr_vld3[5+k] !== 1'b1 || tr_dat3[5+k] !== 8'(17*(k+1))) begin errors++; $display("FAIL skew3_out%0d: got vld=%0h data=%0h expected vld=1 data=%0h", k, tr_vld3[5+k], tr_dat3[5+k], 8'(17*(k+1))); end
        end
        checks++; if (tr_vld3[9] !== 1'b0 || tr_done3[11] !== 1'b1) begin errors++; $display("FAIL skew3_tail: got vld9=%0h done11=%0h expected 0/1", tr_vld3[9], tr_done3[11]); end
    endtask

    task automatic test_wrap_clamp();
        int n, nd;
        start_m = 32'h1 << 3;                   // start while busy must not disturb the job
        do_start(3'd6, 4'd12);
        base_addr = 3'd2; len = 4'd1;
        record(24);
        for (int k = 0; k < 8; k++) begin
            checks++; if (tr_en0[k] !== 1'b1 || tr_addr0[k] !== 3'((6+k)%8)) begin errors++; $display("FAIL wrap_addr%0d: got en=%0h addr=%0d expected en=1 addr=%0d", k, tr_en0[k], tr_addr0[k], (6+k)%8); end
        end
        checks++; if (tr_dat0[2] !== 8'h77 || tr_dat0[4] !== 8'h11 || tr_dat0[9] !== 8'h66) begin errors++; $display("FAIL wrap_data: got %0h/%0h/%0h expected 77/11/66", tr_dat0[2], tr_dat0[4], tr_dat0[9]); end
        n = 0; nd = 0;
        for (int c = 0; c < 24; c++) begin
            n  += int'(tr_vld0[c]);
            nd += int'(tr_done0[c]);
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL wrap_vld_count: got %0d expected 8", n); end
        checks++; if (tr_en0[8] !== 1'b0 || nd !== 1) begin errors++; $display("FAIL wrap_end: got en8=%0h dones=%0d expected 0/1", tr_en0[8], nd); end
    endtask

    task automatic test_stall();
        int n;
        logic [5:0] exp_v;
        stall_m = 32'h0000_000C;                // stall cycles 2 and 3, after the second read
        do_start(3'd0, 4'd4);
        record(20);
        exp_v = 6'b110011;                       // c2..c7, MSB first
        for (int i = 0; i < 6; i++) begin
            checks++; if (tr_vld0[2+i] !== exp_v[5-i]) begin errors++; $display("FAIL stall_vld_c%0d: got %0h expected %0h", 2+i, tr_vld0[2+i], exp_v[5-i]); end
        end
        checks++; if (tr_dat0[2] !== 8'h11 || tr_dat0[3] !== 8'h22 || tr_dat0[6] !== 8'h33 || tr_dat0[7] !== 8'h44) begin errors++; $display("FAIL stall_data: got %0h %0h %0h %0h expected 11 22 33 44", tr_dat0[2], tr_dat0[3], tr_dat0[6], tr_dat0[7]); end
        checks++; if (tr_en0[2] !== 1'b0 || tr_addr0[4] !== 3'd2 || tr_addr0[5] !== 3'd3) begin errors++; $display("FAIL stall_reads: got en2=%0h a4=%0d a5=%0d expected 0/2/3", tr_en0[2], tr_addr0[4], tr_addr0[5]); end
        n = 0;
        for (int c = 0; c < 20; c++) n += int'(tr_vld0[c]);
        checks++; if (n !== 4) begin errors++; $display("FAIL stall_vld_count: got %0d expected 4", n); end
    endtask

    task automatic test_zero_len();
        int n;
        do_start(3'd3, 4'd0);
        record(8);
        checks++; if (tr_done0[0] !== 1'b0 || tr_done0[1] !== 1'b1 || tr_done0[2] !== 1'b0) begin errors++; $display("FAIL zero_done: got %0h%0h%0h expected 010", tr_done0[0], tr_done0[1], tr_done0[2]); end
        n = 0;
        for (int c = 0; c < 8; c++) n += int'(tr_en0[c]) + int'(tr_vld0[c]) + int'(tr_vld3[c]);
        checks++; if (n !== 0) begin errors++; $display("FAIL zero_activity: got %0d reads+vld expected 0", n); end
        checks++; if (tr_busy0[0] !== 1'b1 || tr_pe0[0] !== 1'b0 || tr_busy0[2] !== 1'b0) begin errors++; $display("FAIL zero_ctrl: got busy0=%0h pe0=%0h busy2=%0h expected 1/0/0", tr_busy0[0], tr_pe0[0], tr_busy0[2]); end
    endtask

    task automatic test_pe_doing();
        int nd;
        pd_m = 32'h0000_07FF;                   // busy through c10: five cycles past the last out_vld (c5)
        do_start(3'd0, 4'd4);
        record(20);
        nd = 0;
        for (int c = 0; c < 20; c++) nd += int'(tr_done0[c]);
        checks++; if (nd !== 1 || tr_done0[13] !== 1'b1) begin errors++; $display("FAIL pedoing_done: got count=%0d at13=%0h expected 1/1", nd, tr_done0[13]); end
        checks++; if (tr_pe0[8] !== 1'b1 || tr_pe0[11] !== 1'b1 || tr_pe0[12] !== 1'b0) begin errors++; $display("FAIL pedoing_pe_en: got %0h/%0h/%0h expected 1/1/0", tr_pe0[8], tr_pe0[11], tr_pe0[12]); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_start(3'd0, 4'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;                      // two reads issued, first operand on the output
        checks++; if (rd_en0 !== 1'b1 || vld0 !== 1'b1) begin errors++; $display("FAIL midrst_pre: got en=%0h vld=%0h expected 1/1", rd_en0, vld0); end
        rst = 1'b1;
        #1;
        checks++; if (rd_en0 !== 1'b0 || addr0 !== 3'd0 || vld0 !== 1'b0 || dat0 !== 8'h00) begin errors++; $display("FAIL midrst_data: got en=%0h addr=%0d vld=%0h data=%0h expected 0", rd_en0, addr0, vld0, dat0); end
        checks++; if (pe_en0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got pe_en=%0h busy=%0h done=%0h busy3=%0h expected 0", pe_en0, busy0, done0, busy3); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        record(12);
        n = 0;
        for (int c = 0; c < 12; c++) n += int'(tr_done0[c]) + int'(tr_done3[c]) + int'(tr_vld0[c]);
        checks++; if (n !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d events expected 0", n); end
        do_start(3'd3, 4'd2);
        record(12);
        checks++; if (tr_addr0[0] !== 3'd3 || tr_addr0[1] !== 3'd4) begin errors++; $display("FAIL midrst_restart_addr: got %0d,%0d expected 3,4", tr_addr0[0], tr_addr0[1]); end
        checks++; if (tr_dat0[2] !== 8'h44 || tr_dat0[3] !== 8'h55 || tr_done0[6] !== 1'b1) begin errors++; $display("FAIL midrst_restart_out: got %0h %0h done6=%0h expected 44 55 1", tr_dat0[2], tr_dat0[3], tr_done0[6]); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(17*(i+1));
        test_reset();
        test_basic();
        test_skew3();
        test_wrap_clamp();
        test_stall();
        test_zero_len();
        test_pe_doing();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
